wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the RISC-V pipeline; sits directly upstream of register_file.
- Accepts retiring instructions from the MEM stage and selects the writeback source: ALU result, load data or PC+4.
- Waits for the data-memory read response on loads, then aligns and sign/zero-extends the load data.
- Drives register_file's wr_en/wr_addr/wr_data through registered outputs, one write per retired instruction.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_valid  in  1  MEM stage presents an instruction.
- wb_ready  out  1  stage can accept; high only in IDLE.
- mem_reg_wr  in  1  instruction writes rd.
- mem_rd_addr  in  ADDR_W  destination register.
- mem_wb_sel  in  2  source select: 00 ALU, 01 LOAD, 10 PC+4, 11 ALU.
- mem_alu_result  in  DATA_W  ALU result.
- mem_pc_plus4  in  DATA_W  link value.
- mem_load_funct3  in  3  load type.
- mem_byte_offset  in  2  address[1:0] of the load.
- dmem_rvalid  in  1  load data valid, one-cycle pulse.
- dmem_rdata  in  DATA_W  raw 32-bit memory word.
- wr_en  out  1  register_file write enable.
- wr_addr  out  ADDR_W  register_file write address.
- wr_data  out  DATA_W  register_file write data.
- retire_count  out  64  present only with WB_RETIRE_CNT_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE; wr_en=0, wr_addr=0, wr_data=0; pending load discarded; retire_count=0.
- FSM states: IDLE, WAIT_LOAD.
  - wb_ready = (state==IDLE), purely combinational from state.
- Accept = mem_valid && wb_ready, sampled at rising edge.
- IDLE, accept, mem_wb_sel != 01:
  - at that edge wr_en <= mem_reg_wr && (mem_rd_addr != 0); wr_addr <= mem_rd_addr; wr_data <= ALU or PC+4 per select.
  - State stays IDLE.
  - Write visible to register_file one cycle after accept.
- IDLE, accept, mem_wb_sel == 01:
  - latch rd_addr, reg_wr, funct3, byte_offset; wr_en <= 0; state -> WAIT_LOAD.
- IDLE, no accept: wr_en <= 0. wr_addr/wr_data hold their last values.
- WAIT_LOAD, dmem_rvalid=0: wr_en <= 0; mem_valid ignored (wb_ready=0); stay.
- WAIT_LOAD, dmem_rvalid=1:
  - wr_en <= latched reg_wr && rd != 0; wr_addr <= latched rd; wr_data <= extended data; state -> IDLE.
  - Next accept is possible on the following cycle.
- dmem_rvalid while in IDLE: ignored (stale response); no write.
- Load extension, with b = byte at offset and h = halfword at offset[1] (offset[0] ignored for halves):
  - 000 LB: sign-extend b.
  - 001 LH: sign-extend h.
  - 010 LW: full word.
  - 100 LBU: zero-extend b.
  - 101 LHU: zero-extend h.
  - 011/110/111: treated as LW.
- Byte lanes are little-endian: offset 0 = bits[7:0], offset 3 = bits[31:24].
- rd == x0: never asserts wr_en, but the instruction still retires.
- wr_en is a single-cycle pulse per retiring instruction; there are never two writes for one instruction.
- Reset asserted in WAIT_LOAD: immediate return to IDLE. A dmem_rvalid arriving after reset release is ignored.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - 64-bit retire_count port exists, reset to 0.
  - Increments by 1 on each retire event: non-load accept, or dmem_rvalid in WAIT_LOAD.
  - Counts regardless of reg_wr or rd==x0; wraps modulo 2^64.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. ALU writeback:
   - Stimulus: mem_valid=1, sel=00, rd=5, reg_wr=1, alu=0xDEADBEEF.
   - Response: next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
2. x0 suppression and PC+4:
   - Stimulus: sel=10, rd=0, pc_plus4=0x00000104.
   - Response: wr_en stays 0. Then rd=1 with the same values: wr_en=1, wr_data=0x00000104.
3. Signed and unsigned loads:
   - Stimulus: LB with offset=3, rd=6; wb_ready=0 until response; after 3 cycles dmem_rdata=0x80FF7F01 with rvalid.
   - Response: next cycle wr_data=0xFFFFFF80, wr_addr=6.
   - Repeat with LBU: 0x00000080. LHU offset=2: 0x000080FF. LH offset=0: 0x00007F01.
4. Backpressure:
   - Stimulus: in WAIT_LOAD, hold mem_valid=1 with sel=00, rd=7.
   - Response: no accept and no write until the cycle after rvalid. The rd=7 write then follows one cycle later.
5. Reset mid-load:
   - Stimulus: assert rst in WAIT_LOAD, release, then pulse dmem_rvalid.
   - Response: wr_en stays 0 and wb_ready=1 immediately after reset.
6. Retire counter (WB_RETIRE_CNT_EN defined):
   - Stimulus: 2 ALU ops, 1 load, 1 rd=x0 op.
   - Response: retire_count=4. With the macro undefined, the bench compiles without the port.

Source files
------------

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage -- writeback stage of the RISC-V pipeline, feeding register_file.
//
// Takes one retiring instruction at a time from the MEM stage and picks the
// writeback source: the ALU result, the load data, or PC+4. For a load it
// waits for the data-memory response, then aligns and extends the returned
// word. The register-file write port (wr_en/wr_addr/wr_data) is registered.
// Each retiring instruction produces at most one single-cycle wr_en pulse.
//
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit retire_count
// output and its counter. When the macro is undefined, the port and the
// counter are not built.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   mem_valid         MEM stage presents an instruction
//   wb_ready          stage can accept (high only in IDLE)
//   mem_reg_wr        instruction writes rd
//   mem_rd_addr       destination register
//   mem_wb_sel        00 ALU, 01 LOAD, 10 PC+4, 11 ALU
//   mem_alu_result    ALU result
//   mem_pc_plus4      link value
//   mem_load_funct3   load type (LB/LH/LW/LBU/LHU)
//   mem_byte_offset   address[1:0] of the load
//   dmem_rvalid       load data valid, one-cycle pulse
//   dmem_rdata        raw memory word
//   wr_en/wr_addr/wr_data  register_file write port (registered)
//   retire_count      retired-instruction count (WB_RETIRE_CNT_EN only)
//
// Handshake: an instruction is accepted on a rising edge where
// mem_valid && wb_ready. wb_ready is combinational from the state register.
// The MEM stage must hold its payload stable until that edge. dmem_rvalid is
// honoured only in WAIT_LOAD; a pulse seen in IDLE is a stale response and
// is dropped.
//
// The FSM has two states, so wb_ready fully exposes the current state.
// ----------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              wb_ready,
    input  logic              mem_reg_wr,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [1:0]        mem_wb_sel,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic [2:0]        mem_load_funct3,
    input  logic [1:0]        mem_byte_offset,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]       retire_count,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t            state_q;
    logic [ADDR_W-1:0] ld_rd_q;
    logic              ld_reg_wr_q;
    logic [2:0]        ld_funct3_q;
    logic [1:0]        ld_offset_q;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_data_d;
    logic [DATA_W-1:0] direct_data_d;

    assign wb_ready = (state_q == IDLE);

    // Byte lanes are little-endian. For halfwords only offset[1] matters.
    always_comb begin
        ld_byte = 8'h00;
        case (ld_offset_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ld_offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    // funct3 encodings that are not LB/LH/LBU/LHU fall back to a full word.
    always_comb begin
        load_data_d = dmem_rdata;
        case (ld_funct3_q)
            3'b000:  load_data_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data_d = {24'h000000, ld_byte};
            3'b101:  load_data_d = {16'h0000, ld_half};
            default: load_data_d = dmem_rdata;
        endcase
    end

    // Select 11 aliases the ALU result.
    assign direct_data_d = (mem_wb_sel == SEL_PC4) ? mem_pc_plus4 : mem_alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            ld_rd_q     <= '0;
            ld_reg_wr_q <= 1'b0;
            ld_funct3_q <= 3'b000;
            ld_offset_q <= 2'b00;
`ifdef WB_RETIRE_CNT_EN
            retire_count <= 64'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid) begin
                        if (mem_wb_sel == SEL_LOAD) begin
                            ld_rd_q     <= mem_rd_addr;
                            ld_reg_wr_q <= mem_reg_wr;
                            ld_funct3_q <= mem_load_funct3;
                            ld_offset_q <= mem_byte_offset;
                            state_q     <= WAIT_LOAD;
                        end else begin
                            // Writes to x0 are dropped, but the instruction still retires.
                            wr_en   <= mem_reg_wr && (mem_rd_addr != '0);
                            wr_addr <= mem_rd_addr;
                            wr_data <= direct_data_d;
`ifdef WB_RETIRE_CNT_EN
                            retire_count <= retire_count + 64'd1;
`endif
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        wr_en   <= ld_reg_wr_q && (ld_rd_q != '0);
                        wr_addr <= ld_rd_q;
                        wr_data <= load_data_d;
                        state_q <= IDLE;
`ifdef WB_RETIRE_CNT_EN
                        retire_count <= retire_count + 64'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// The stimulus tasks push the expected {wr_addr, wr_data} of every real
// register write into exp_q. The monitor runs on the falling edge and pops
// and compares an entry on each wr_en pulse. A wr_en pulse with nothing
// queued counts as an unexpected write.
// ----------------------------------------------------------------------------
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int EXP_W  = ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              mem_valid = 1'b0;
    logic              wb_ready;
    logic              mem_reg_wr = 1'b0;
    logic [ADDR_W-1:0] mem_rd_addr = '0;
    logic [1:0]        mem_wb_sel = 2'b00;
    logic [DATA_W-1:0] mem_alu_result = '0;
    logic [DATA_W-1:0] mem_pc_plus4 = '0;
    logic [2:0]        mem_load_funct3 = 3'b000;
    logic [1:0]        mem_byte_offset = 2'b00;
    logic              dmem_rvalid = 1'b0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]       retire_count;
`endif

    wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .wb_ready       (wb_ready),
        .mem_reg_wr     (mem_reg_wr),
        .mem_rd_addr    (mem_rd_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_load_funct3(mem_load_funct3),
        .mem_byte_offset(mem_byte_offset),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
`ifdef WB_RETIRE_CNT_EN
        .retire_count   (retire_count),
`endif
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, wr_addr, wr_data}, 64'd0);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", {59'd0, wr_addr}, {59'd0, e[EXP_W-1:DATA_W]});
                check("write_data", {32'd0, wr_data}, {32'd0, e[DATA_W-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (wb_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (wb_ready !== 1'b1) check("ready_timeout", {63'd0, wb_ready}, 64'd1);
    endtask

    // Issue a non-load instruction; pushes the expected write if one should occur.
    task automatic issue_direct(input logic [1:0] sel, input logic [4:0] rd, input logic reg_wr,
                                input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [31:0] exp_data);
        wait_ready();
        mem_valid = 1'b1; mem_wb_sel = sel; mem_rd_addr = rd; mem_reg_wr = reg_wr;
        mem_alu_result = alu; mem_pc_plus4 = pc4;
        if (reg_wr && rd != 5'd0) exp_q.push_back({rd, exp_data});
        step();
        mem_valid = 1'b0;
    endtask

    // Accept a load; returns with the DUT in WAIT_LOAD.
    task automatic issue_load_req(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
        wait_ready();
        mem_valid = 1'b1; mem_wb_sel = 2'b01; mem_rd_addr = rd; mem_reg_wr = 1'b1;
        mem_load_funct3 = f3; mem_byte_offset = off;
        mem_alu_result = 32'hBAD0BAD0;
        step();
        mem_valid = 1'b0;
        check("ready_low_in_wait", {63'd0, wb_ready}, 64'd0);
    endtask

    task automatic respond(input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp_data);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        if (rd != 5'd0) exp_q.push_back({rd, exp_data});
        step();
        dmem_rvalid = 1'b0;
        check("ready_after_load", {63'd0, wb_ready}, 64'd1);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                           input int delay, input logic [31:0] rdata, input logic [31:0] exp_data);
        issue_load_req(f3, off, rd);
        for (int i = 0; i < delay; i++) step();
        respond(rdata, rd, exp_data);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #2;
        check("reset_wr_en",   {63'd0, wr_en}, 64'd0);
        check("reset_wr_addr", {59'd0, wr_addr}, 64'd0);
        check("reset_wr_data", {32'd0, wr_data}, 64'd0);
        check("reset_ready",   {63'd0, wb_ready}, 64'd1);
        step(); step();
        rst = 1'b0;
        step();

        // ALU writeback, with pulse-shape checks
        wait_ready();
        mem_valid = 1'b1; mem_wb_sel = 2'b00; mem_rd_addr = 5'd5; mem_reg_wr = 1'b1;
        mem_alu_result = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        mem_valid = 1'b0;
        check("alu_wr_en_pulse", {63'd0, wr_en}, 64'd1);
        step();
        check("alu_wr_en_drop", {63'd0, wr_en}, 64'd0);
        check("alu_wr_data_hold", {32'd0, wr_data}, 64'h00000000DEADBEEF);

        // x0 suppression, then PC+4 to x1
        issue_direct(2'b10, 5'd0, 1'b1, 32'h11111111, 32'h00000104, 32'h00000104);
        check("x0_no_write", {63'd0, wr_en}, 64'd0);
        issue_direct(2'b10, 5'd1, 1'b1, 32'h11111111, 32'h00000104, 32'h00000104);
        // sel=11 aliases ALU; reg_wr=0 produces no write
        issue_direct(2'b11, 5'd9, 1'b1, 32'h0000A5A5, 32'h00000200, 32'h0000A5A5);
        issue_direct(2'b00, 5'd10, 1'b0, 32'h12345678, 32'h0, 32'h12345678);
        step();

        // Signed / unsigned loads on 0x80FF7F01 (bytes LE: 01 7F FF 80)
        do_load(3'b000, 2'd3, 5'd6, 3, 32'h80FF7F01, 32'hFFFFFF80); // LB
        do_load(3'b100, 2'd3, 5'd6, 3, 32'h80FF7F01, 32'h00000080); // LBU
        do_load(3'b101, 2'd2, 5'd6, 3, 32'h80FF7F01, 32'h000080FF); // LHU
        do_load(3'b001, 2'd0, 5'd6, 3, 32'h80FF7F01, 32'h00007F01); // LH
        do_load(3'b000, 2'd1, 5'd11, 0, 32'h80FF7F01, 32'h0000007F); // LB +ve
        do_load(3'b000, 2'd2, 5'd12, 1, 32'h80FF7F01, 32'hFFFFFFFF); // LB FF
        do_load(3'b001, 2'd2, 5'd13, 2, 32'h80FF7F01, 32'hFFFF80FF); // LH upper
        do_load(3'b101, 2'd3, 5'd14, 1, 32'h80FF7F01, 32'h000080FF); // offset[0] ignored
        do_load(3'b010, 2'd0, 5'd15, 1, 32'h80FF7F01, 32'h80FF7F01); // LW
        do_load(3'b011, 2'd2, 5'd16, 1, 32'h80FF7F01, 32'h80FF7F01); // 011 -> LW
        do_load(3'b110, 2'd1, 5'd17, 1, 32'hCAFEF00D, 32'hCAFEF00D); // 110 -> LW
        do_load(3'b000, 2'd0, 5'd0, 1, 32'h000000FF, 32'h0);        // load to x0

        // Backpressure: ALU op held on mem_valid during WAIT_LOAD
        issue_load_req(3'b010, 2'd0, 5'd18);
        mem_valid = 1'b1; mem_wb_sel = 2'b00; mem_rd_addr = 5'd7; mem_reg_wr = 1'b1;
        mem_alu_result = 32'h00000777;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready_low", {63'd0, wb_ready}, 64'd0);
            check("bp_no_write", {63'd0, wr_en}, 64'd0);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
        exp_q.push_back({5'd18, 32'h55AA55AA});
        step();
        dmem_rvalid = 1'b0;
        check("bp_load_write_addr", {59'd0, wr_addr}, 64'd18);
        exp_q.push_back({5'd7, 32'h00000777});
        step();
        mem_valid = 1'b0;
        check("bp_alu_write_addr", {59'd0, wr_addr}, 64'd7);
        step();
        check("bp_single_pulse", {63'd0, wr_en}, 64'd0);

        // Reset in WAIT_LOAD, then a stale response
        issue_load_req(3'b010, 2'd0, 5'd19);
        step();
        rst = 1'b1;
        #1;
        check("rst_ready_async", {63'd0, wb_ready}, 64'd1);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        step();
        rst = 1'b0;
        check("rst_release_ready", {63'd0, wb_ready}, 64'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        step();
        dmem_rvalid = 1'b0;
        check("stale_no_write", {63'd0, wr_en}, 64'd0);
        check("stale_ready", {63'd0, wb_ready}, 64'd1);
        step();

`ifdef WB_RETIRE_CNT_EN
        check("cnt_after_reset", retire_count, 64'd0);
`endif
        // Retire mix: 2 ALU, 1 load, 1 x0 op
        issue_direct(2'b00, 5'd20, 1'b1, 32'h00000020, 32'h0, 32'h00000020);
        issue_direct(2'b00, 5'd21, 1'b1, 32'h00000021, 32'h0, 32'h00000021);
        do_load(3'b100, 2'd1, 5'd22, 2, 32'h0000AB00, 32'h000000AB);
        issue_direct(2'b00, 5'd0, 1'b1, 32'h00000099, 32'h0, 32'h0);
        step();
`ifdef WB_RETIRE_CNT_EN
        check("retire_count", retire_count, 64'd4);
`endif

        step(); step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
